// File: rtl/input_buff_ctrl_if.sv
// Handshake/control bundle between the input-buffer sequencer and its host/consumer.
// Signal prefixes are from the sequencer's point of view (i_ = into it, o_ = out of it).
interface input_buff_ctrl_if #(
    parameter int NDATA = 128
) ();
    localparam int NDATA_LOG = $clog2(NDATA);

    logic                 i_start;
    logic                 i_abort;
    logic                 i_contMode;
    logic                 i_ack;
    logic [NDATA_LOG-1:0] o_cntOut;
    logic                 o_bufEna;
    logic                 o_dataValid;
    logic                 o_busy;
    logic [15:0]          o_frameCnt;
    logic                 o_timeoutErr;

    modport master (
        output i_start, i_abort, i_contMode, i_ack,
        input  o_cntOut, o_bufEna, o_dataValid, o_busy, o_frameCnt, o_timeoutErr
    );

    modport slave (
        input  i_start, i_abort, i_contMode, i_ack,
        output o_cntOut, o_bufEna, o_dataValid, o_busy, o_frameCnt, o_timeoutErr
    );
endinterface

// File: rtl/input_buff_ctrl.sv
// Sequencer for the 4-channel input buffer: prime, capture one NDATA frame, freeze, hand off.
// Define INBUF_CTRL_WDOG_EN to add the DONE-state ack watchdog (sticky timeoutErr, frame dropped).
module input_buff_ctrl #(
    parameter int NDATA       = 128,
    parameter int PRIME_CYC   = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input_buff_ctrl_if.slave bus
);
    localparam int                   NDATA_LOG  = $clog2(NDATA);
    localparam logic [NDATA_LOG-1:0] LAST_IDX   = NDATA_LOG'(NDATA - 1);
    localparam logic [3:0]           PRIME_LAST = 4'(PRIME_CYC - 1);

    if (NDATA < 4 || (NDATA & (NDATA - 1)) != 0 || PRIME_CYC < 1 || PRIME_CYC > 15
        || ACK_TIMEOUT < 1) begin : g_param_check
        $error("input_buff_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRIME   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_prime_cnt;
    logic [3:0]           w_prime_nxt;
    logic [NDATA_LOG-1:0] r_cnt;
    logic [NDATA_LOG-1:0] w_cnt_nxt;
    logic [15:0]          r_frame_cnt;
    logic [15:0]          w_frame_nxt;
    logic                 r_bufEna;
    logic                 r_dataValid;
    logic                 r_busy;
    logic                 r_timeoutErr;
    logic                 w_bufEna_nxt;
    logic                 w_dataValid_nxt;
    logic                 w_busy_nxt;
    logic                 w_timeoutErr_nxt;
    logic                 w_ack_done;
    logic                 w_timeout;

`ifdef INBUF_CTRL_WDOG_EN
    localparam int WAIT_W = ($clog2(ACK_TIMEOUT + 1) > 11) ? $clog2(ACK_TIMEOUT + 1) : 11;

    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;

    // Counter reads 0 on the first DONE cycle; an ack in the expiry cycle still completes normally.
    always_comb begin
        w_wait_nxt = '0;
        w_timeout  = 1'b0;
        if (r_state == S_DONE) begin
            w_wait_nxt = r_wait + 1'b1;
            w_timeout  = !bus.i_ack && (r_wait == WAIT_W'(ACK_TIMEOUT - 1));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait <= '0;
        end else begin
            r_wait <= w_wait_nxt;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_prime_cnt  <= '0;
            r_cnt        <= '0;
            r_frame_cnt  <= '0;
            r_bufEna     <= 1'b1;
            r_dataValid  <= 1'b0;
            r_busy       <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prime_cnt  <= w_prime_nxt;
            r_cnt        <= w_cnt_nxt;
            r_frame_cnt  <= w_frame_nxt;
            r_bufEna     <= w_bufEna_nxt;
            r_dataValid  <= w_dataValid_nxt;
            r_busy       <= w_busy_nxt;
            r_timeoutErr <= w_timeoutErr_nxt;
        end
    end

    // Next state; abort outranks every other transition
    always_comb begin
        w_state_nxt = r_state;
        w_prime_nxt = '0;
        w_ack_done  = 1'b0;
        if (bus.i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        w_state_nxt = S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (r_prime_cnt == PRIME_LAST) begin
                        w_state_nxt = S_CAPTURE;
                    end else begin
                        w_prime_nxt = r_prime_cnt + 4'd1;
                    end
                end
                S_CAPTURE: begin
                    if (r_cnt == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.i_ack) begin
                        w_ack_done  = 1'b1;
                        w_state_nxt = bus.i_contMode ? S_PRIME : S_IDLE;
                    end else if (w_timeout) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output values for the state being entered
    always_comb begin
        w_cnt_nxt = '0;
        if (r_state == S_CAPTURE && w_state_nxt == S_CAPTURE) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (w_state_nxt == S_DONE) begin
            w_cnt_nxt = r_cnt;
        end
        w_bufEna_nxt     = !(w_state_nxt == S_PRIME || w_state_nxt == S_CAPTURE);
        w_dataValid_nxt  = (w_state_nxt == S_DONE);
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_frame_nxt      = r_frame_cnt + 16'(w_ack_done);
        w_timeoutErr_nxt = r_timeoutErr | (w_timeout & !bus.i_abort);
    end

    assign bus.o_cntOut     = r_cnt;
    assign bus.o_bufEna     = r_bufEna;
    assign bus.o_dataValid  = r_dataValid;
    assign bus.o_busy       = r_busy;
    assign bus.o_frameCnt   = r_frame_cnt;
    assign bus.o_timeoutErr = r_timeoutErr;
endmodule

// File: tb/tb_input_buff_ctrl.sv
// Scoreboard bench for input_buff_ctrl: directed scenarios followed by random control traffic,
// checked cycle by cycle against a "time since arm" reference model.
module tb_input_buff_ctrl;
    localparam int NDATA       = 8;
    localparam int PRIME_CYC   = 2;
    localparam int ACK_TIMEOUT = 16;
    localparam int FRAME_END   = PRIME_CYC + NDATA;
`ifdef INBUF_CTRL_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  cnt;
        logic        bufEna;
        logic        dv;
        logic        busy;
        logic [15:0] fc;
        logic        terr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    input_buff_ctrl_if #(.NDATA(NDATA)) bus ();

    input_buff_ctrl #(
        .NDATA      (NDATA),
        .PRIME_CYC  (PRIME_CYC),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    bit          m_armed  = 1'b0;
    int          m_t      = 0;
    logic [15:0] m_frames = '0;
    bit          m_terr   = 1'b0;
    bit          cont     = 1'b0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference: a frame is "time since arm"; PRIME, CAPTURE and DONE are just ranges of m_t.
    task automatic model_step(input bit r, input bit s, input bit a, input bit c, input bit k);
        exp_t e;
        if (r) begin
            m_armed = 1'b0; m_t = 0; m_frames = '0; m_terr = 1'b0;
        end else if (a) begin
            m_armed = 1'b0;
        end else if (!m_armed) begin
            if (s) begin
                m_armed = 1'b1; m_t = 0;
            end
        end else if (m_t >= FRAME_END) begin
            if (k) begin
                m_frames = m_frames + 16'd1;
                if (c) m_t = 0;
                else   m_armed = 1'b0;
            end else if (WDOG && (m_t - FRAME_END) == ACK_TIMEOUT - 1) begin
                m_terr = 1'b1; m_armed = 1'b0;
            end else begin
                m_t++;
            end
        end else begin
            m_t++;
        end
        if (!m_armed || m_t < PRIME_CYC) e.cnt = 3'd0;
        else if (m_t < FRAME_END)        e.cnt = 3'(m_t - PRIME_CYC);
        else                             e.cnt = 3'(NDATA - 1);
        e.bufEna = !(m_armed && m_t < FRAME_END);
        e.dv     = m_armed && m_t >= FRAME_END;
        e.busy   = m_armed;
        e.fc     = m_frames;
        e.terr   = m_terr;
        sb.push_back(e);
    endtask

    task automatic drive(input bit r, input bit s, input bit a, input bit k);
        @(negedge clk);
        #1;
        rst            = r;
        bus.i_start    = s;
        bus.i_abort    = a;
        bus.i_contMode = cont;
        bus.i_ack      = k;
        model_step(r, s, a, cont, k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Runs until the model's capture index reaches idx (bounded)
    task automatic run_to_idx(input int idx);
        for (int i = 0; i < 40 && !(m_armed && m_t == PRIME_CYC + idx); i++) idle(1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("cntOut",     16'(bus.o_cntOut),     16'(e.cnt));
                check("bufEna",     16'(bus.o_bufEna),     16'(e.bufEna));
                check("dataValid",  16'(bus.o_dataValid),  16'(e.dv));
                check("busy",       16'(bus.o_busy),       16'(e.busy));
                check("frameCnt",   bus.o_frameCnt,        e.fc);
                check("timeoutErr", 16'(bus.o_timeoutErr), 16'(e.terr));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_contMode = 1'b0; bus.i_ack = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // single frame, ack four cycles after dataValid rises
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(13);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // continuous mode, ack on first dataValid cycle, three frames
        cont = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100 && m_frames < 16'd4; i++)
            drive(1'b0, 1'b0, 1'b0, m_armed && m_t >= FRAME_END);
        cont = 1'b0;
        for (int i = 0; i < 30 && m_armed; i++)
            drive(1'b0, 1'b0, 1'b0, m_armed && m_t >= FRAME_END);
        idle(2);

        // abort mid-capture, then a normal frame
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        run_to_idx(4);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(12);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // ignored inputs: start and ack while capturing, start while done
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < FRAME_END - 1; i++) drive(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // reset mid-frame
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        run_to_idx(5);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // no ack: watchdog expiry or indefinite hold
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(FRAME_END + 100);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) cont = ~cont;
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
        end

        idle(2);
        @(negedge clk);
        #2;
        check("drain", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
